// File: rtl/bist_ora_misr.sv
// rtl/bist_ora_misr.sv - 3-bit MISR output response analyser for full-adder BIST (optional watchdog: ORA_TIMEOUT_EN)
module bist_ora_misr #(
  parameter logic [2:0] SEED          = 3'b000,
  parameter logic [2:0] GOLDEN_SIG    = 3'b001,
  parameter logic [3:0] PATTERN_COUNT = 4'd7,
  parameter int         TIMEOUT       = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       cut_sum,
  input  logic       cut_carry,
  output logic [2:0] signature,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic       timeout
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMPRESS = 2'd1,
    ST_COMPARE  = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  state_t     state_q;
  logic [2:0] sig_q;
  logic [2:0] sig_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic       fail_q;

  // Next MISR value for polynomial x^3+x+1 with d[1]=carry, d[0]=sum, and saturating vector count
  always_comb begin
    sig_d    = sig_q;
    sig_d[0] = sig_q[2] ^ cut_sum;
    sig_d[1] = sig_q[0] ^ sig_q[2] ^ cut_carry;
    sig_d[2] = sig_q[1];
    cnt_d    = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  end

`ifdef ORA_TIMEOUT_EN
  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wd_q;
  logic           timeout_q;

  // Run controller with watchdog: compresses responses, judges the signature, holds the verdict
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sig_q     <= SEED;
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_COMPRESS;
            sig_q     <= SEED;
            cnt_q     <= 4'd0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            wd_q      <= '0;
          end
        end
        ST_COMPRESS: begin
          if (in_valid && in_last) begin
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            state_q <= ST_COMPARE;
          end else if (wd_q == WD_LAST) begin
            // Response stream stalled: end the run as a failure
            state_q   <= ST_DONE;
            fail_q    <= 1'b1;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            if (in_valid) begin
              sig_q <= sig_d;
              cnt_q <= cnt_d;
            end
            wd_q <= wd_q + 1'b1;
          end
        end
        ST_COMPARE: begin
          if ((sig_q == GOLDEN_SIG) && (cnt_q == PATTERN_COUNT)) begin
            pass_q <= 1'b1;
          end else begin
            fail_q <= 1'b1;
          end
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  // Run controller: compresses responses, judges the signature, holds the verdict
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sig_q   <= SEED;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_COMPRESS;
            sig_q   <= SEED;
            cnt_q   <= 4'd0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        ST_COMPRESS: begin
          if (in_valid) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (in_last) begin
              state_q <= ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if ((sig_q == GOLDEN_SIG) && (cnt_q == PATTERN_COUNT)) begin
            pass_q <= 1'b1;
          end else begin
            fail_q <= 1'b1;
          end
          state_q <= ST_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

endmodule
